// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers for the Gray-pointer FIFO controller.
// Helpers work on a wide zero-extended word. Callers cast their W-bit pointers
// up to gray_word_t and the result back down to W bits. Leading zeros are
// preserved by both conversions, so any width up to GRAY_MAX_W works unchanged.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = g;
        for (int i = 1; i < GRAY_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Full compare for w-bit Gray pointers (w >= 2): the write pointer is a
    // full lap ahead when it matches the read pointer with its two MSBs flipped.
    function automatic logic gray_full(input gray_word_t wr_g,
                                       input gray_word_t rd_g,
                                       input int         w);
        gray_word_t mask;
        mask = gray_word_t'(2'b11) << (w - 2);
        return wr_g == (rd_g ^ mask);
    endfunction

endpackage : gray_pkg

// File: rtl/gray_ptr.sv
// gray_ptr: W-bit pointer held as a binary register plus its registered Gray
// image. Clear wins over increment; the pointer wraps naturally at 2^W.
module gray_ptr
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clear_i,
    input  logic         incr_i,
    output logic [W-1:0] bin_o,
    output logic [W-1:0] gray_o
);

    logic [W-1:0] bin_q;
    logic [W-1:0] bin_d;
    logic [W-1:0] gray_q;
    logic [W-1:0] gray_d;

    // Next pointer value and its Gray image, computed together so both
    // registers always hold a consistent pair.
    always_comb begin
        bin_d = bin_q;
        if (clear_i) begin
            bin_d = '0;
        end else if (incr_i) begin
            bin_d = bin_q + W'(1);
        end
        gray_d = W'(bin2gray(gray_word_t'(bin_d)));
    end

    // Pointer registers; asynchronous reset clears both images at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin_o  = bin_q;
    assign gray_o = gray_q;

endmodule : gray_ptr

// File: rtl/gray_fifo_ctrl.sv
// gray_fifo_ctrl: single-clock FIFO controller for an external 2^ADDR_W-entry
// array. Full/empty come from the registered Gray pointers, which are also
// exported so a dual-clock variant can synchronise them without change.
// Optional feature: define GRAY_FIFO_CTRL_COUNT_EN to add the count_o port.
module gray_fifo_ctrl
    import gray_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W:0]   wr_ptr_gray_o,
    output logic [ADDR_W:0]   rd_ptr_gray_o
`ifdef GRAY_FIFO_CTRL_COUNT_EN
    ,
    output logic [ADDR_W:0]   count_o
`endif
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wr_bin;
    logic [PTR_W-1:0] wr_gray;
    logic [PTR_W-1:0] rd_bin;
    logic [PTR_W-1:0] rd_gray;
    logic             empty;
    logic             full;
    logic             wr_acc;
    logic             rd_acc;

    gray_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (flush_i),
        .incr_i  (wr_acc),
        .bin_o   (wr_bin),
        .gray_o  (wr_gray)
    );

    gray_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (flush_i),
        .incr_i  (rd_acc),
        .bin_o   (rd_bin),
        .gray_o  (rd_gray)
    );

    // Flags depend only on registered Gray pointers, so there is no input-to-flag path.
    always_comb begin
        empty = (wr_gray == rd_gray);
        full  = gray_full(gray_word_t'(wr_gray), gray_word_t'(rd_gray), PTR_W);
    end

    // Handshakes: flush suppresses both transfers even when the flags allow them.
    always_comb begin
        wr_acc = wr_valid_i & ~full  & ~flush_i;
        rd_acc = rd_ready_i & ~empty & ~flush_i;
    end

    assign wr_ready_o    = ~full;
    assign rd_valid_o    = ~empty;
    assign wr_en_o       = wr_acc;
    assign wr_addr_o     = wr_bin[ADDR_W-1:0];
    assign rd_addr_o     = rd_bin[ADDR_W-1:0];
    assign wr_ptr_gray_o = wr_gray;
    assign rd_ptr_gray_o = rd_gray;

`ifdef GRAY_FIFO_CTRL_COUNT_EN
    // Occupancy: the lap bit makes the modular difference span 0..2^ADDR_W.
    assign count_o = wr_bin - rd_bin;
`else
    // Lap bits are only consumed by the occupancy subtractor.
    logic unused_lap_bits;
    assign unused_lap_bits = wr_bin[ADDR_W] ^ rd_bin[ADDR_W];
`endif

endmodule : gray_fifo_ctrl
